cpu_state_regs: RTL and testbench

- Architectural state holder for the CPU core.
- Wraps the general-purpose register file (`register_file`) and the program counter (`program_counter`) as two independent sub-blocks sharing one clock and one reset.
- Register file: 16 x 32-bit registers, three asynchronous read ports, one write/clear port, and one independent +/-4 increment/decrement port.
- PC: 32-bit, writeable, with +4 increment.

---
 rtl/cpu_state_regs_pkg.sv | 14 +
 rtl/cpu_state_regs_program_counter.sv | 35 +++
 rtl/cpu_state_regs_register_file.sv | 58 +++++
 rtl/cpu_state_regs.sv | 54 +++++
 tb/tb_cpu_state_regs.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_state_regs_pkg.sv
// Shared types and constants for the CPU architectural state (register file + PC).
package cpu_state_regs_pkg;

  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned INDEX_WIDTH = 4;
  localparam int unsigned NUM_REGS    = 2 ** INDEX_WIDTH;
  localparam int unsigned STEP        = 4;

  typedef logic [DATA_WIDTH-1:0]  t_reg;
  typedef logic [INDEX_WIDTH-1:0] t_reg_index;

  localparam t_reg STEP_VAL = DATA_WIDTH'(STEP);

endpackage

// File: rtl/cpu_state_regs_program_counter.sv
// 32-bit program counter: load has priority over +STEP increment, else hold.
module program_counter
  import cpu_state_regs_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic write_i,
  input  logic inc_i,
  input  t_reg write_data_i,
  output t_reg pc_o
);

  t_reg pc_q;
  t_reg pc_d;

  always_comb begin
    pc_d = pc_q;
    if (write_i) begin
      pc_d = write_data_i;
    end else if (inc_i) begin
      pc_d = pc_q + STEP_VAL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/cpu_state_regs_register_file.sv
// 16 x 32-bit register file: three async read ports, a clear/write port and an
// independent +/-STEP port; the clear/write port wins on an index collision.
module register_file
  import cpu_state_regs_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       write_i,
  input  logic       inc_i,
  input  logic       dec_i,
  input  t_reg_index write_index_i,
  input  t_reg_index incdec_index_i,
  input  t_reg       write_data_i,
  input  t_reg_index rd1_index_i,
  input  t_reg_index rd2_index_i,
  input  t_reg_index rd3_index_i,
  output t_reg       rd1_data_o,
  output t_reg       rd2_data_o,
  output t_reg       rd3_data_o
);

  t_reg regs_q [NUM_REGS];
  t_reg regs_d [NUM_REGS];

  // Inc/dec applied first so a same-index clear/write overrides it.
  always_comb begin
    regs_d = regs_q;
    if (inc_i && !dec_i) begin
      regs_d[incdec_index_i] = regs_q[incdec_index_i] + STEP_VAL;
    end else if (dec_i && !inc_i) begin
      regs_d[incdec_index_i] = regs_q[incdec_index_i] - STEP_VAL;
    end
    if (clear_i) begin
      regs_d[write_index_i] = '0;
    end else if (write_i) begin
      regs_d[write_index_i] = write_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Reads see stored contents only; no write-to-read bypass.
  assign rd1_data_o = regs_q[rd1_index_i];
  assign rd2_data_o = regs_q[rd2_index_i];
  assign rd3_data_o = regs_q[rd3_index_i];

endmodule

// File: rtl/cpu_state_regs.sv
// CPU architectural state: wires the register file and program counter to
// a shared clock and asynchronous active-low reset.
module cpu_state_regs
  import cpu_state_regs_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       write,
  input  logic       inc,
  input  logic       dec,
  input  t_reg_index write_index,
  input  t_reg_index incdec_index,
  input  t_reg       write_data,
  input  t_reg_index read_reg1_index,
  input  t_reg_index read_reg2_index,
  input  t_reg_index read_reg3_index,
  output t_reg       read_reg1_data,
  output t_reg       read_reg2_data,
  output t_reg       read_reg3_data,
  input  logic       pc_write,
  input  logic       pc_inc,
  input  t_reg       pc_write_data,
  output t_reg       pc_read_data
);

  register_file u_register_file (
    .clk            (clock),
    .rst_n          (reset),
    .clear_i        (clear),
    .write_i        (write),
    .inc_i          (inc),
    .dec_i          (dec),
    .write_index_i  (write_index),
    .incdec_index_i (incdec_index),
    .write_data_i   (write_data),
    .rd1_index_i    (read_reg1_index),
    .rd2_index_i    (read_reg2_index),
    .rd3_index_i    (read_reg3_index),
    .rd1_data_o     (read_reg1_data),
    .rd2_data_o     (read_reg2_data),
    .rd3_data_o     (read_reg3_data)
  );

  program_counter u_program_counter (
    .clk          (clock),
    .rst_n        (reset),
    .write_i      (pc_write),
    .inc_i        (pc_inc),
    .write_data_i (pc_write_data),
    .pc_o         (pc_read_data)
  );

endmodule

// File: tb/tb_cpu_state_regs.sv
// Bench for cpu_state_regs: directed plan steps, async reset, then random traffic
// compared against an array-based model of the architectural state.
module tb_cpu_state_regs;

  logic        clock;
  logic        reset;
  logic        clear, write, inc, dec;
  logic [3:0]  write_index, incdec_index;
  logic [31:0] write_data;
  logic [3:0]  r1i, r2i, r3i;
  logic [31:0] rd1, rd2, rd3;
  logic        pc_write, pc_inc;
  logic [31:0] pc_write_data, pc_read_data;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] m_regs [16];
  logic [31:0] m_pc;

  cpu_state_regs dut (
    .clock           (clock),
    .reset           (reset),
    .clear           (clear),
    .write           (write),
    .inc             (inc),
    .dec             (dec),
    .write_index     (write_index),
    .incdec_index    (incdec_index),
    .write_data      (write_data),
    .read_reg1_index (r1i),
    .read_reg2_index (r2i),
    .read_reg3_index (r3i),
    .read_reg1_data  (rd1),
    .read_reg2_data  (rd2),
    .read_reg3_data  (rd3),
    .pc_write        (pc_write),
    .pc_inc          (pc_inc),
    .pc_write_data   (pc_write_data),
    .pc_read_data    (pc_read_data)
  );

  initial begin
    clock = 1'b0;
    forever #50 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one clock edge, stated as the rules read.
  task automatic model_edge();
    logic [31:0] nxt [16];
    bit          port_a_active;
    bit          same_index;
    nxt = m_regs;
    port_a_active = clear || write;
    same_index    = (incdec_index == write_index);
    if (inc && !dec && !(port_a_active && same_index))
      nxt[incdec_index] = m_regs[incdec_index] + 32'd4;
    if (dec && !inc && !(port_a_active && same_index))
      nxt[incdec_index] = m_regs[incdec_index] - 32'd4;
    if (clear)      nxt[write_index] = 32'd0;
    else if (write) nxt[write_index] = write_data;
    m_regs = nxt;
    if (pc_write)    m_pc = pc_write_data;
    else if (pc_inc) m_pc = m_pc + 32'd4;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
    m_pc = 32'd0;
  endtask

  // Every register through each read port, plus the PC.
  task automatic check_all(input string ctx);
    for (int i = 0; i < 16; i++) begin
      r1i = 4'(i);
      r2i = 4'((i + 5) % 16);
      r3i = 4'((i + 11) % 16);
      #1;
      chk($sformatf("%s rd1 r%0d", ctx, i), rd1, m_regs[i]);
      chk($sformatf("%s rd2 r%0d", ctx, (i + 5) % 16), rd2, m_regs[(i + 5) % 16]);
      chk($sformatf("%s rd3 r%0d", ctx, (i + 11) % 16), rd3, m_regs[(i + 11) % 16]);
    end
    chk($sformatf("%s pc", ctx), pc_read_data, m_pc);
  endtask

  task automatic tick(input string ctx);
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_all(ctx);
  endtask

  task automatic expect_reg(input string tag, input logic [3:0] idx, input logic [31:0] exp);
    r1i = idx;
    #1;
    chk(tag, rd1, exp);
  endtask

  initial begin
    reset = 1'b0;
    clear = 0; write = 0; inc = 0; dec = 0;
    write_index = '0; incdec_index = '0; write_data = '0;
    r1i = '0; r2i = '0; r3i = '0;
    pc_write = 0; pc_inc = 0; pc_write_data = '0;
    model_reset();
    #10;
    check_all("por");
    @(negedge clock);
    reset = 1'b1;

    // Inc r1, then concurrent write r2
    inc = 1; incdec_index = 4'd1;
    tick("inc1");
    expect_reg("plan r1=4", 4'd1, 32'd4);
    expect_reg("plan r0=0", 4'd0, 32'd0);
    write = 1; write_index = 4'd2; write_data = 32'hDEADBEEF;
    r1i = 4'd2; #1;
    chk("no bypass r2 old", rd1, 32'd0);
    tick("inc_wr");
    expect_reg("plan r1=8", 4'd1, 32'd8);
    expect_reg("plan r2=deadbeef", 4'd2, 32'hDEADBEEF);

    // Clear r2 while inc continues, then dec
    write = 0; clear = 1;
    tick("clr_inc");
    expect_reg("plan r1=c", 4'd1, 32'hC);
    expect_reg("plan r2=0", 4'd2, 32'd0);
    clear = 0; inc = 0; dec = 1;
    tick("dec1");
    expect_reg("plan r1=8 dec", 4'd1, 32'd8);

    // Conflicts
    dec = 0; inc = 1; incdec_index = 4'd5;
    write = 1; write_index = 4'd5; write_data = 32'h100;
    tick("wr_inc_same");
    expect_reg("conflict r5=100", 4'd5, 32'h100);
    inc = 0; clear = 1; write = 1; write_data = 32'h55;
    tick("clr_wr_same");
    expect_reg("conflict r5=0", 4'd5, 32'd0);
    clear = 0; write = 0; inc = 1; dec = 1; incdec_index = 4'd1;
    tick("inc_dec_both");
    expect_reg("conflict r1 held", 4'd1, 32'd8);

    // Wrap-around
    inc = 0; dec = 0; write = 1; write_index = 4'd3; write_data = 32'hFFFFFFFC;
    tick("wr_r3");
    write = 0; inc = 1; incdec_index = 4'd3;
    tick("wrap_up");
    expect_reg("wrap r3=0", 4'd3, 32'd0);
    inc = 0; dec = 1; incdec_index = 4'd4;
    tick("wrap_down");
    expect_reg("wrap r4=fffffffc", 4'd4, 32'hFFFFFFFC);

    // PC sequence
    dec = 0; pc_inc = 1;
    tick("pc_inc");
    chk("pc=4", pc_read_data, 32'd4);
    pc_write = 1; pc_write_data = 32'hDEADBEEF;
    tick("pc_wr");
    chk("pc=deadbeef", pc_read_data, 32'hDEADBEEF);
    pc_write = 0;
    tick("pc_inc2");
    chk("pc=deadbef3", pc_read_data, 32'hDEADBEF3);
    pc_inc = 0;
    tick("pc_hold");
    chk("pc hold", pc_read_data, 32'hDEADBEF3);

    // Async reset mid-cycle with state loaded and enables active
    write = 1; write_index = 4'd7; write_data = 32'h1234; pc_inc = 1;
    r1i = 4'd1; r2i = 4'd2; r3i = 4'd4;
    #3;
    reset = 1'b0;
    #1;
    chk("rst r1", rd1, 32'd0);
    chk("rst r2", rd2, 32'd0);
    chk("rst r4", rd3, 32'd0);
    chk("rst pc", pc_read_data, 32'd0);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    check_all("rst_held");
    reset = 1'b1;
    tick("post_rst");
    expect_reg("post rst r7", 4'd7, 32'h1234);
    chk("post rst pc", pc_read_data, 32'd4);

    // Random traffic against the model
    for (int n = 0; n < 250; n++) begin
      clear = ($urandom_range(0, 7) == 0);
      write = ($urandom_range(0, 2) == 0);
      inc   = ($urandom_range(0, 1) == 1);
      dec   = ($urandom_range(0, 2) == 0);
      write_index  = 4'($urandom_range(0, 15));
      incdec_index = ($urandom_range(0, 3) == 0) ? write_index : 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       write_data = 32'hFFFFFFFC;
        1:       write_data = 32'($urandom_range(0, 8));
        default: write_data = $urandom;
      endcase
      pc_write = ($urandom_range(0, 4) == 0);
      pc_inc   = ($urandom_range(0, 1) == 1);
      pc_write_data = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC : $urandom;
      tick($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
